// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use hazard unit: tracks DEPTH in-flight producers and issues a
// registered per-port forward select aligned to EX, plus a combinational load-use stall.

module fwd_hazard_port #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = 2
) (
    input  logic [REG_AW-1:0]            rs_i,
    input  logic                         rs_used_i,
    input  logic [DEPTH:1]               vld_i,
    input  logic [DEPTH:1][REG_AW-1:0]   rd_i,
    input  logic [DEPTH:1]               regwrite_i,
    input  logic [DEPTH:1]               memread_i,
    output logic [SEL_W-1:0]             sel_o,
    output logic                         load_hit_o
);
    logic [DEPTH:1] prod;
    logic           unused_tail;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_prod
        assign prod[k] = vld_i[k] & regwrite_i[k] & (rd_i[k] != '0) &
                         (rd_i[k] == rs_i) & rs_used_i;
    end

    // Scan oldest to youngest so the youngest producer overrides; RDEPTH is excluded
    // because the regfile write lands before the read.
    always_comb begin
        sel_o = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (prod[k]) sel_o = SEL_W'(k);
        end
    end

    always_comb begin
        load_hit_o = 1'b0;
        for (int k = 1; k <= LOAD_LAT; k++) begin
            if (prod[k] & memread_i[k]) load_hit_o = 1'b1;
        end
    end

    assign unused_tail = prod[DEPTH] ^ (^memread_i);
endmodule

module fwd_hazard_unit #(
    parameter int  REG_AW   = 5,
    parameter int  NUM_RS   = 2,
    parameter int  DEPTH    = 3,
    parameter int  LOAD_LAT = 1,
    parameter int  CNT_W    = 16,
    localparam int SEL_W    = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    input  logic                      id_regwrite_i,
    input  logic                      id_memread_i,
    input  logic [NUM_RS*REG_AW-1:0]  id_rs_i,
    input  logic [NUM_RS-1:0]         id_rs_used_i,
    input  logic                      flush_i,
    input  logic                      hold_i,
    output logic                      stall_o,
    output logic [NUM_RS*SEL_W-1:0]   fwd_sel_o,
    output logic                      ex_valid_o,
    output logic [CNT_W-1:0]          stall_count_o
);
    logic [DEPTH:1]                 vld_pipe_q, vld_pipe_d;
    logic [DEPTH:1][REG_AW-1:0]     rd_pipe_q, rd_pipe_d;
    logic [DEPTH:1]                 rw_pipe_q, rw_pipe_d;
    logic [DEPTH:1]                 mr_pipe_q, mr_pipe_d;
    logic [NUM_RS-1:0][SEL_W-1:0]   fwd_sel_q, fwd_sel_d;
    logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;

    logic [NUM_RS-1:0][SEL_W-1:0]   sel_next;
    logic [NUM_RS-1:0]              load_hit;
    logic                           id_take;

    for (genvar p = 0; p < NUM_RS; p++) begin : g_port
        fwd_hazard_port #(
            .REG_AW   (REG_AW),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SEL_W    (SEL_W)
        ) u_port (
            .rs_i       (id_rs_i[p*REG_AW +: REG_AW]),
            .rs_used_i  (id_rs_used_i[p]),
            .vld_i      (vld_pipe_q),
            .rd_i       (rd_pipe_q),
            .regwrite_i (rw_pipe_q),
            .memread_i  (mr_pipe_q),
            .sel_o      (sel_next[p]),
            .load_hit_o (load_hit[p])
        );
    end

    // id_valid gates everything first so X on the other id_* inputs cannot leak out.
    assign stall_o = id_valid_i & ~flush_i & (|load_hit);
    assign id_take = id_valid_i & ~stall_o & ~flush_i;

    always_comb begin
        vld_pipe_d  = vld_pipe_q;
        rd_pipe_d   = rd_pipe_q;
        rw_pipe_d   = rw_pipe_q;
        mr_pipe_d   = mr_pipe_q;
        fwd_sel_d   = fwd_sel_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold_i) begin
            vld_pipe_d[1] = id_take;
            rd_pipe_d[1]  = id_take ? id_rd_i : '0;
            rw_pipe_d[1]  = id_take ? id_regwrite_i : 1'b0;
            mr_pipe_d[1]  = id_take ? id_memread_i : 1'b0;
            for (int k = 2; k <= DEPTH; k++) begin
                vld_pipe_d[k] = vld_pipe_q[k-1];
                rd_pipe_d[k]  = rd_pipe_q[k-1];
                rw_pipe_d[k]  = rw_pipe_q[k-1];
                mr_pipe_d[k]  = mr_pipe_q[k-1];
            end
            fwd_sel_d = id_take ? sel_next : '0;
            if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe_q  <= '0;
            rd_pipe_q   <= '0;
            rw_pipe_q   <= '0;
            mr_pipe_q   <= '0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            rd_pipe_q   <= rd_pipe_d;
            rw_pipe_q   <= rw_pipe_d;
            mr_pipe_q   <= mr_pipe_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid_o    = vld_pipe_q[1];
    assign fwd_sel_o     = fwd_sel_q;
    assign stall_count_o = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: table of per-cycle ID inputs with expected stall and
// forward selects (scoreboarded to the cycle the instruction reaches R1), then corner sequences.

module tb_fwd_hazard_unit;
    localparam int REG_AW = 5;
    localparam int NUM_RS = 2;
    localparam int SEL_W  = 2;
    localparam int NROWS  = 50;

    typedef logic [NUM_RS-1:0][SEL_W-1:0] sel_t;
    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       rw, mr;
        logic [4:0] rs0, rs1;
        logic [1:0] used;
        logic       fl;
        logic       es;
        logic [1:0] s0, s1;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      id_valid, id_regwrite, id_memread, flush, hold;
    logic [REG_AW-1:0]         id_rd;
    logic [NUM_RS*REG_AW-1:0]  id_rs;
    logic [NUM_RS-1:0]         id_rs_used;
    logic                      stall, ex_valid, stall2, ex_valid2;
    logic [NUM_RS*SEL_W-1:0]   fwd_sel, fwd_sel2;
    logic [15:0]               stall_count;
    logic [1:0]                stall_count2;

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    sel_t sbq[$];
    vec_t tbl[NROWS];

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_rs_i(id_rs),
        .id_rs_used_i(id_rs_used), .flush_i(flush), .hold_i(hold), .stall_o(stall),
        .fwd_sel_o(fwd_sel), .ex_valid_o(ex_valid), .stall_count_o(stall_count)
    );

    fwd_hazard_unit #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_rs_i(id_rs),
        .id_rs_used_i(id_rs_used), .flush_i(flush), .hold_i(hold), .stall_o(stall2),
        .fwd_sel_o(fwd_sel2), .ex_valid_o(ex_valid2), .stall_count_o(stall_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int v, rd, rw, mr, rs0, rs1, used, fl, es, s0, s1);
        vec_t r;
        r.v = 1'(v); r.rd = 5'(rd); r.rw = 1'(rw); r.mr = 1'(mr);
        r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.used = 2'(used); r.fl = 1'(fl);
        r.es = 1'(es); r.s0 = 2'(s0); r.s1 = 2'(s1);
        return r;
    endfunction

    task automatic drive(input vec_t r);
        id_valid    = r.v;
        id_rd       = r.rd;
        id_regwrite = r.rw;
        id_memread  = r.mr;
        id_rs       = {r.rs1, r.rs0};
        id_rs_used  = r.used;
        flush       = r.fl;
    endtask

    // One cycle: check stall against current inputs, clock, then check what entered R1.
    task automatic step(input logic exp_stall, input logic acc, input sel_t exp_sel);
        sel_t want;
        #1;
        chk("stall", 32'(stall), 32'(exp_stall));
        if (acc) sbq.push_back(exp_sel);
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(acc));
        if (ex_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty actual=ex_valid expected=no_instr at %0t", $time);
            end else begin
                want = sbq.pop_front();
                chk("fwd_sel", 32'(fwd_sel), 32'(want));
            end
        end else begin
            chk("fwd_sel_bubble", 32'(fwd_sel), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t bub, lw3, rd3;
        bub = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw3 = mk(1, 3, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        rd3 = mk(1, 4, 1, 0, 3, 2, 3, 0, 0, 0, 0);
        for (int i = 0; i < NROWS; i++) tbl[i] = bub;
        //          v  rd rw mr rs0 rs1 used fl es s0 s1
        tbl[0]  = mk(1, 5, 1, 0, 1, 2, 3, 0, 0, 0, 0);   // add x5
        tbl[1]  = mk(1, 6, 1, 0, 5, 5, 3, 0, 0, 1, 1);   // back-to-back reader
        tbl[5]  = mk(1, 5, 1, 0, 1, 2, 3, 0, 0, 0, 0);   // add x5; nop; sub x7,x5,x1
        tbl[7]  = mk(1, 7, 1, 0, 5, 1, 3, 0, 0, 2, 0);
        tbl[11] = mk(1, 5, 1, 0, 1, 2, 3, 0, 0, 0, 0);   // youngest wins
        tbl[12] = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 8, 1, 0, 5, 5, 1, 0, 0, 1, 0);   // p1 not used
        tbl[17] = mk(1, 0, 1, 0, 1, 2, 3, 0, 0, 0, 0);   // x0 producer
        tbl[18] = mk(1, 9, 1, 0, 0, 0, 3, 0, 0, 0, 0);
        tbl[22] = lw3;                                   // load-use
        tbl[23] = mk(1, 4, 1, 0, 3, 2, 3, 0, 1, 0, 0);
        tbl[24] = mk(1, 4, 1, 0, 3, 2, 3, 0, 0, 2, 0);
        tbl[28] = lw3;                                   // flush beats stall
        tbl[29] = mk(1, 4, 1, 0, 3, 2, 3, 1, 0, 0, 0);
        tbl[30] = mk(1, 4, 1, 0, 3, 2, 3, 0, 0, 2, 0);
        tbl[34] = lw3;                                   // unused sources never stall
        tbl[35] = mk(1, 4, 1, 0, 3, 3, 0, 0, 0, 0, 0);
        tbl[39] = lw3;                                   // ALU x3 younger than load x3
        tbl[40] = mk(1, 3, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[41] = mk(1, 10, 1, 0, 3, 3, 3, 0, 0, 1, 1);
        tbl[45] = mk(1, 5, 0, 0, 1, 2, 3, 0, 0, 0, 0);   // regwrite=0 is not a producer
        tbl[46] = mk(1, 11, 1, 0, 5, 5, 3, 0, 0, 0, 0);

        rst = 1'b1;
        hold = 1'b0;
        drive(bub);
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_fwd_sel", 32'(fwd_sel), 32'd0);
        chk("rst_count", 32'(stall_count), 32'd0);
        #5 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NROWS; i++) begin
            drive(tbl[i]);
            step(tbl[i].es, tbl[i].v & ~tbl[i].es & ~tbl[i].fl, {tbl[i].s1, tbl[i].s0});
            if (tbl[i].es) exp_cnt++;
        end
        chk("table_count", 32'(stall_count), 32'(exp_cnt));

        // Hold during a load-use stall: stall stays up, everything frozen.
        drive(lw3);
        step(1'b0, 1'b1, '0);
        drive(rd3);
        hold = 1'b1;
        #1;
        chk("hold_stall", 32'(stall), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("hold_stall_cyc", 32'(stall), 32'd1);
            chk("hold_count", 32'(stall_count), 32'(exp_cnt));
            chk("hold_ex_valid", 32'(ex_valid), 32'd1);
            chk("hold_fwd_sel", 32'(fwd_sel), 32'd0);
        end
        hold = 1'b0;
        step(1'b1, 1'b0, '0);
        exp_cnt++;
        chk("post_hold_count", 32'(stall_count), 32'(exp_cnt));
        chk("post_hold_count2", 32'(stall_count2), 32'(exp_cnt));
        step(1'b0, 1'b1, {2'd0, 2'd2});
        for (int c = 0; c < 3; c++) begin drive(bub); step(1'b0, 1'b0, '0); end

        // Async reset mid-sequence drops the in-flight load.
        drive(lw3);
        step(1'b0, 1'b1, '0);
        drive(rd3);
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("mid_rst_fwd_sel", 32'(fwd_sel), 32'd0);
        chk("mid_rst_count", 32'(stall_count), 32'd0);
        sbq.delete();
        exp_cnt = 0;
        rst = 1'b0;
        step(1'b0, 1'b1, '0);

        // Five load-use stalls: 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            drive(lw3);
            step(1'b0, 1'b1, '0);
            drive(rd3);
            step(1'b1, 1'b0, '0);
            exp_cnt++;
            step(1'b0, 1'b1, {2'd0, 2'd2});
            chk("sat_count16", 32'(stall_count), 32'(exp_cnt));
            chk("sat_count2", 32'(stall_count2), 32'((exp_cnt > 3) ? 3 : exp_cnt));
        end

        // X on id_* with id_valid low must not reach outputs.
        id_valid    = 1'b0;
        id_rd       = 'x;
        id_regwrite = 1'bx;
        id_memread  = 1'bx;
        id_rs       = 'x;
        id_rs_used  = 'x;
        flush       = 1'b0;
        step(1'b0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
